nthash_feeder: RTL

Upstream stage for `md4block` in the NT-hash cracking pipeline. It accepts a candidate password as a stream of 8-bit ASCII characters and widens each character to UTF-16LE. It then applies MD4 padding and the bit length to form one 512-bit block, starts `md4block` with the standard initial state, and holds the inputs stable until the result returns. On completion it emits the 128-bit NT hash, byte-ordered as the conventional hex digest.

---
 rtl/nthash_feeder.sv | 129 ++++++++++++
 1 files changed

// File: rtl/nthash_feeder.sv
// Front end for md4block: packs an ASCII password as UTF-16LE into one padded MD4 block,
// launches md4block with the standard IV and returns the byte-ordered NT hash.
module nthash_feeder #(
  parameter int unsigned MAX_CHARS = 27
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [7:0]   in_char,
  input  logic         in_last,
  output logic         in_ready,
  output logic         blk_irdy,
  output logic [511:0] blk_data,
  output logic [31:0]  blk_state_a,
  output logic [31:0]  blk_state_b,
  output logic [31:0]  blk_state_c,
  output logic [31:0]  blk_state_d,
  input  logic         md4_ordy,
  input  logic [31:0]  md4_a,
  input  logic [31:0]  md4_b,
  input  logic [31:0]  md4_c,
  input  logic [31:0]  md4_d,
  output logic         hash_valid,
  output logic [127:0] hash,
  output logic         err
);

  localparam int unsigned CntW = $clog2(MAX_CHARS + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_CHARS);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDrain} state_e;

  state_e          state_q;
  logic [CntW-1:0] count_q;
  logic            ovf_q;

  logic [8:0]  char_lsb;
  logic [8:0]  pad_lsb;
  logic [63:0] msg_bits;
  logic [63:0] len_le;
  logic        beat;
  logic        too_long;

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  assign blk_state_a = 32'h67452301;
  assign blk_state_b = 32'hEFCDAB89;
  assign blk_state_c = 32'h98BADCFE;
  assign blk_state_d = 32'h10325476;

  // Character n occupies bytes 2n (ASCII) and 2n+1 (zero); pad byte lands at 2(n+1).
  always_comb begin
    char_lsb = 9'(496 - 16 * int'(count_q));
    pad_lsb  = 9'(488 - 16 * int'(count_q));
    msg_bits = (64'(count_q) + 64'd1) << 4;
    len_le   = '0;
    for (int j = 0; j < 8; j++) begin
      len_le[63 - 8*j -: 8] = msg_bits[8*j +: 8];
    end
    beat     = in_valid && in_ready;
    too_long = ovf_q || (count_q >= MaxCnt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      blk_data   <= '0;
      blk_irdy   <= 1'b0;
      hash_valid <= 1'b0;
      err        <= 1'b0;
      hash       <= '0;
      in_ready   <= 1'b1;
    end else begin
      blk_irdy   <= 1'b0;
      hash_valid <= 1'b0;
      err        <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (beat) begin
            if (count_q < MaxCnt) begin
              blk_data[char_lsb +: 16] <= {in_char, 8'h00};
              count_q                  <= count_q + CntW'(1);
            end else begin
              ovf_q <= 1'b1;
            end
            if (in_last) begin
              if (too_long) begin
                // Later assignments win: drop whatever this beat wrote.
                err      <= 1'b1;
                blk_data <= '0;
                count_q  <= '0;
                ovf_q    <= 1'b0;
              end else begin
                blk_data[pad_lsb +: 8] <= 8'h80;
                blk_data[63:0]         <= len_le;
                blk_irdy               <= 1'b1;
                in_ready               <= 1'b0;
                state_q                <= StIssue;
              end
            end
          end
        end
        StIssue: state_q <= StWait;
        StWait: begin
          if (md4_ordy) begin
            hash       <= {bswap(md4_a), bswap(md4_b), bswap(md4_c), bswap(md4_d)};
            hash_valid <= 1'b1;
            state_q    <= StDrain;
          end
        end
        StDrain: begin
          // md4block holds ordy for two cycles; leave only once it drops.
          if (!md4_ordy) begin
            blk_data <= '0;
            count_q  <= '0;
            in_ready <= 1'b1;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
